// File: rtl/fft_pkg.sv
// fft_pkg: constants, widths and state encoding shared by the FFT post-processing blocks
package fft_pkg;
  localparam int N_FFT  = 1024;
  localparam int LOG2_N = 10;
  localparam int FS_HZ  = 500000;
  localparam int MAG_W  = 28;
  localparam int BIN_W  = 10;
  typedef enum logic [1:0] {IDLE, COLLECT, CALC, DONE} peak_state_t;
endpackage

// File: rtl/bin_to_hz.sv
// bin_to_hz: registered conversion of an FFT bin number to floor(bin*FS/2^SHIFT) Hz
module bin_to_hz
  import fft_pkg::*;
#(
  parameter int FS    = FS_HZ,
  parameter int SHIFT = LOG2_N
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [BIN_W-1:0] bin,
  output logic [31:0]      hz
);
  logic [BIN_W+31:0] prod;
  assign prod = (BIN_W+32)'(bin) * (BIN_W+32)'(FS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hz <= '0;
    else if (en) hz <= prod[SHIFT +: 32];
endmodule

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: per-frame strongest positive-frequency bin with neighbours and Hz value
module fft_peak_finder
  import fft_pkg::*;
#(
  parameter int N_FFT   = fft_pkg::N_FFT,
  parameter int LOG2_N  = fft_pkg::LOG2_N,
  parameter int FS_HZ   = fft_pkg::FS_HZ,
  parameter int MIN_BIN = 1,
  parameter logic [MAG_W-1:0] MIN_MAG = 28'h0010000
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [MAG_W-1:0] magnitude,
  input  logic [BIN_W-1:0] bin_index,
  input  logic             magnitude_valid,
  input  logic             processing_done,
  output logic [BIN_W-1:0] peak_bin,
  output logic [MAG_W-1:0] peak_mag,
  output logic [MAG_W-1:0] left_mag,
  output logic [MAG_W-1:0] right_mag,
  output logic [31:0]      peak_freq_hz,
  output logic             no_peak,
  output logic             seq_error,
  output logic             result_valid,
  output logic             busy
);
  localparam logic [BIN_W-1:0] LO   = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] HI   = BIN_W'(N_FFT/2-1);
  localparam logic [BIN_W-1:0] LAST = BIN_W'(N_FFT-1);
  peak_state_t state, nxt;
  logic [MAG_W-1:0] cur_max, cur_left, cur_right, prev_mag;
  logic [BIN_W-1:0] cur_bin, exp_idx;
  logic need_right, seq_acc, take, better;
  logic [31:0] hz;
  // bin 0 locks onto a frame in IDLE and is consumed in that same cycle
  assign take   = magnitude_valid && (state == COLLECT || (state == IDLE && enable && bin_index == '0));
  assign better = bin_index >= LO && bin_index <= HI && magnitude > cur_max;
  always_comb begin
    nxt  = state;
    busy = state != IDLE;
    case (state)
      IDLE:    nxt = take ? COLLECT : IDLE;
      COLLECT: nxt = (magnitude_valid ? bin_index == LAST : processing_done) ? CALC : COLLECT;
      CALC:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_max      <= '0;
      cur_left     <= '0;
      cur_right    <= '0;
      prev_mag     <= '0;
      cur_bin      <= '0;
      exp_idx      <= '0;
      need_right   <= 1'b0;
      seq_acc      <= 1'b0;
      peak_bin     <= '0;
      peak_mag     <= '0;
      left_mag     <= '0;
      right_mag    <= '0;
      peak_freq_hz <= '0;
      no_peak      <= 1'b0;
      seq_error    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= state == DONE;
      if (take) begin
        if (bin_index != exp_idx) seq_acc <= 1'b1;
        exp_idx  <= bin_index + 1'b1;
        prev_mag <= magnitude;
        if (better) begin
          cur_max    <= magnitude;
          cur_bin    <= bin_index;
          cur_left   <= prev_mag;
          need_right <= 1'b1;
        end else if (need_right) begin
          cur_right  <= magnitude;
          need_right <= 1'b0;
        end
      end else if (state == COLLECT && processing_done) begin
        seq_acc <= 1'b1;
        if (need_right) begin
          cur_right  <= '0;
          need_right <= 1'b0;
        end
      end
      if (state == DONE) begin
        peak_bin     <= cur_bin;
        peak_mag     <= cur_max;
        left_mag     <= cur_left;
        right_mag    <= cur_right;
        peak_freq_hz <= hz;
        no_peak      <= cur_max < MIN_MAG;
        seq_error    <= seq_acc;
        cur_max      <= '0;
        cur_bin      <= '0;
        cur_left     <= '0;
        cur_right    <= '0;
        prev_mag     <= '0;
        exp_idx      <= '0;
        need_right   <= 1'b0;
        seq_acc      <= 1'b0;
      end
    end
  end
  bin_to_hz #(.FS(FS_HZ), .SHIFT(LOG2_N)) u_hz (
    .clk(clk), .rst_n(rst_n), .en(state == CALC), .bin(cur_bin), .hz(hz)
  );
endmodule
